// File: rtl/fft_pkg.sv
// Shared types and fixed-point helpers for the FFT datapath.
// Helpers work on 64-bit signed values and callers cast results down to their own widths.
package fft_pkg;

    localparam int FFT_DATA_W = 16;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } cplx_t;

    // Add half an LSB of the shifted result, then arithmetic shift (round half up).
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                       input int sh);
        logic signed [63:0] half;
        half = 64'sd1 <<< (sh - 1);
        return (x + half) >>> sh;
    endfunction

    function automatic logic signed [63:0] sat_to_w(input  logic signed [63:0] x,
                                                    input  int               w,
                                                    output logic             sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        sat = 1'b1;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end else begin
            r   = x;
            sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/butterfly_lane_pipe.sv
// One radix-2 butterfly lane: S1 operand/conj register, S2 complex multiply and round,
// S3 add/sub, optional halving, saturation. All stages advance together on i_adv.
module butterfly_lane_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_adv,
    input  logic signed [DATA_W-1:0] i_a_re,
    input  logic signed [DATA_W-1:0] i_a_im,
    input  logic signed [DATA_W-1:0] i_b_re,
    input  logic signed [DATA_W-1:0] i_b_im,
    input  logic signed [DATA_W-1:0] i_w_re,
    input  logic signed [DATA_W-1:0] i_w_im,
    input  logic                     i_conj,
    input  logic                     i_scale,
    output logic signed [DATA_W-1:0] o_x_re,
    output logic signed [DATA_W-1:0] o_x_im,
    output logic signed [DATA_W-1:0] o_y_re,
    output logic signed [DATA_W-1:0] o_y_im,
    output logic                     o_sat
);

    localparam int PW = 2 * DATA_W;
    localparam int TW = 2 * DATA_W + 1;
    localparam int RW = DATA_W + 2;
    localparam int SW = DATA_W + 3;
    localparam logic signed [DATA_W-1:0] W_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] W_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    logic signed [DATA_W-1:0] w_w_im_c;
    logic signed [DATA_W-1:0] r1_a_re, r1_a_im, r1_b_re, r1_b_im, r1_w_re, r1_w_im;
    logic                     r1_scale;
    logic signed [PW-1:0]     w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [TW-1:0]     w_t_re, w_t_im;
    logic signed [RW-1:0]     w_tr_re, w_tr_im;
    logic signed [DATA_W-1:0] r2_a_re, r2_a_im;
    logic signed [RW-1:0]     r2_t_re, r2_t_im;
    logic                     r2_scale;
    logic signed [SW-1:0]     w_s_xr, w_s_xi, w_s_yr, w_s_yi;
    logic signed [DATA_W-1:0] w_x_re, w_x_im, w_y_re, w_y_im;
    logic                     w_sat_xr, w_sat_xi, w_sat_yr, w_sat_yi;

    // Negating the most negative twiddle would wrap, so it clamps to the maximum.
    assign w_w_im_c = !i_conj ? i_w_im : ((i_w_im == W_MIN) ? W_MAX : -i_w_im);

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_a_re  <= '0;
            r1_a_im  <= '0;
            r1_b_re  <= '0;
            r1_b_im  <= '0;
            r1_w_re  <= '0;
            r1_w_im  <= '0;
            r1_scale <= 1'b0;
        end else if (i_adv) begin
            r1_a_re  <= i_a_re;
            r1_a_im  <= i_a_im;
            r1_b_re  <= i_b_re;
            r1_b_im  <= i_b_im;
            r1_w_re  <= i_w_re;
            r1_w_im  <= w_w_im_c;
            r1_scale <= i_scale;
        end
    end

    assign w_p_rr  = PW'(r1_b_re) * PW'(r1_w_re);
    assign w_p_ii  = PW'(r1_b_im) * PW'(r1_w_im);
    assign w_p_ri  = PW'(r1_b_re) * PW'(r1_w_im);
    assign w_p_ir  = PW'(r1_b_im) * PW'(r1_w_re);
    assign w_t_re  = TW'(w_p_rr) - TW'(w_p_ii);
    assign w_t_im  = TW'(w_p_ri) + TW'(w_p_ir);
    assign w_tr_re = RW'(round_shift(64'(w_t_re), DATA_W - 1));
    assign w_tr_im = RW'(round_shift(64'(w_t_im), DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_a_re  <= '0;
            r2_a_im  <= '0;
            r2_t_re  <= '0;
            r2_t_im  <= '0;
            r2_scale <= 1'b0;
        end else if (i_adv) begin
            r2_a_re  <= r1_a_re;
            r2_a_im  <= r1_a_im;
            r2_t_re  <= w_tr_re;
            r2_t_im  <= w_tr_im;
            r2_scale <= r1_scale;
        end
    end

    function automatic logic signed [DATA_W-1:0] finish(input  logic signed [SW-1:0] s,
                                                        input  logic                 sc,
                                                        output logic                 sat);
        logic signed [63:0] v;
        v = sc ? round_shift(64'(s), 1) : 64'(s);
        return DATA_W'(sat_to_w(v, DATA_W, sat));
    endfunction

    assign w_s_xr = SW'(r2_a_re) + SW'(r2_t_re);
    assign w_s_xi = SW'(r2_a_im) + SW'(r2_t_im);
    assign w_s_yr = SW'(r2_a_re) - SW'(r2_t_re);
    assign w_s_yi = SW'(r2_a_im) - SW'(r2_t_im);

    always_comb begin
        w_sat_xr = 1'b0;
        w_sat_xi = 1'b0;
        w_sat_yr = 1'b0;
        w_sat_yi = 1'b0;
        w_x_re   = finish(w_s_xr, r2_scale, w_sat_xr);
        w_x_im   = finish(w_s_xi, r2_scale, w_sat_xi);
        w_y_re   = finish(w_s_yr, r2_scale, w_sat_yr);
        w_y_im   = finish(w_s_yi, r2_scale, w_sat_yi);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_x_re <= '0;
            o_x_im <= '0;
            o_y_re <= '0;
            o_y_im <= '0;
            o_sat  <= 1'b0;
        end else if (i_adv) begin
            o_x_re <= w_x_re;
            o_x_im <= w_x_im;
            o_y_re <= w_y_re;
            o_y_im <= w_y_im;
            o_sat  <= w_sat_xr | w_sat_xi | w_sat_yr | w_sat_yi;
        end
    end

endmodule

// File: rtl/butterfly_stage_pipe.sv
// NUM_BFLY-lane pipelined butterfly stage. Owns the valid pipe, the single global
// advance enable shared by every lane, and the sticky saturation flag.
module butterfly_stage_pipe
    import fft_pkg::*;
#(
    parameter int NUM_BFLY = 8,
    parameter int DATA_W   = FFT_DATA_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [4*NUM_BFLY-1:0][DATA_W-1:0]    in_data,
    input  logic [2*NUM_BFLY-1:0][DATA_W-1:0]    in_twiddle,
    input  logic                                 in_conj,
    input  logic                                 in_scale,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [4*NUM_BFLY-1:0][DATA_W-1:0]    out_data,
    output logic                                 out_sat,
    output logic                                 sat_sticky,
    input  logic                                 sat_clr
);

    localparam int STAGES = 3;

    logic [STAGES:1]     r_vld_pipe;
    logic                r_sat_sticky;
    logic                w_adv;
    logic [NUM_BFLY-1:0] w_lane_sat;

    // A bubble in the last stage lets the whole pipe move even without out_ready.
    assign w_adv    = !r_vld_pipe[STAGES] || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
        end
    end

    for (genvar k = 0; k < NUM_BFLY; k++) begin : g_lane
        butterfly_lane_pipe #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_adv   (w_adv),
            .i_a_re  (in_data[4*k]),
            .i_a_im  (in_data[4*k+1]),
            .i_b_re  (in_data[4*k+2]),
            .i_b_im  (in_data[4*k+3]),
            .i_w_re  (in_twiddle[2*k]),
            .i_w_im  (in_twiddle[2*k+1]),
            .i_conj  (in_conj),
            .i_scale (in_scale),
            .o_x_re  (out_data[4*k]),
            .o_x_im  (out_data[4*k+1]),
            .o_y_re  (out_data[4*k+2]),
            .o_y_im  (out_data[4*k+3]),
            .o_sat   (w_lane_sat[k])
        );
    end

    assign out_valid = r_vld_pipe[STAGES];
    assign out_sat   = |w_lane_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_sat) begin
            r_sat_sticky <= 1'b1;
        end else if (sat_clr) begin
            r_sat_sticky <= 1'b0;
        end
    end

    assign sat_sticky = r_sat_sticky;

endmodule

// File: tb/tb_butterfly_stage_pipe.sv
// Bench for butterfly_stage_pipe: directed vector table, randomized backpressured stream
// against an arithmetic reference model, and reset-discard sequence.
module tb_butterfly_stage_pipe;
    import fft_pkg::*;

    localparam int NB = 8;
    localparam int DW = 16;
    localparam int NTX = 20;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [4*NB-1:0][DW-1:0] in_data;
    logic [2*NB-1:0][DW-1:0] in_twiddle;
    logic                    in_conj;
    logic                    in_scale;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*NB-1:0][DW-1:0] out_data;
    logic                    out_sat;
    logic                    sat_sticky;
    logic                    sat_clr;

    butterfly_stage_pipe #(.NUM_BFLY(NB), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_twiddle (in_twiddle),
        .in_conj    (in_conj),
        .in_scale   (in_scale),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky),
        .sat_clr    (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct { cplx_t a; cplx_t b; cplx_t w; } lane_in_t;
    typedef struct { int xr; int xi; int yr; int yi; bit sat; } lane_out_t;
    typedef struct { lane_in_t l; bit conj; bit scale; lane_out_t exp; } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampw(input longint v, inout bit s);
        if (v > 32767)  begin s = 1'b1; return 32767;  end
        if (v < -32768) begin s = 1'b1; return -32768; end
        return int'(v);
    endfunction

    // Reference: exact complex arithmetic with floor-based rounding, then clamp.
    function automatic lane_out_t model(input lane_in_t l, input bit conj, input bit scale);
        lane_out_t o;
        longint ar, ai, br, bi, wr, wi, tr, ti, x[4];
        bit s;
        ar = longint'($signed(l.a.re)); ai = longint'($signed(l.a.im));
        br = longint'($signed(l.b.re)); bi = longint'($signed(l.b.im));
        wr = longint'($signed(l.w.re)); wi = longint'($signed(l.w.im));
        if (conj) wi = (wi == -32768) ? 32767 : -wi;
        tr = (br * wr - bi * wi + 16384) >>> 15;
        ti = (br * wi + bi * wr + 16384) >>> 15;
        x[0] = ar + tr; x[1] = ai + ti; x[2] = ar - tr; x[3] = ai - ti;
        s = 1'b0;
        for (int i = 0; i < 4; i++) if (scale) x[i] = (x[i] + 1) >>> 1;
        o.xr = clampw(x[0], s); o.xi = clampw(x[1], s);
        o.yr = clampw(x[2], s); o.yi = clampw(x[3], s);
        o.sat = s;
        return o;
    endfunction

    function automatic vec_t mkv(input int ar, ai, br, bi, wr, wi, input bit cj, sc,
                                 input int xr, xi, yr, yi, input bit s);
        vec_t v;
        v.l.a.re = 16'(ar); v.l.a.im = 16'(ai);
        v.l.b.re = 16'(br); v.l.b.im = 16'(bi);
        v.l.w.re = 16'(wr); v.l.w.im = 16'(wi);
        v.conj = cj; v.scale = sc;
        v.exp.xr = xr; v.exp.xi = xi; v.exp.yr = yr; v.exp.yi = yi; v.exp.sat = s;
        return v;
    endfunction

    task automatic put_lane(input int k, input lane_in_t l);
        in_data[4*k]     = l.a.re;
        in_data[4*k+1]   = l.a.im;
        in_data[4*k+2]   = l.b.re;
        in_data[4*k+3]   = l.b.im;
        in_twiddle[2*k]   = l.w.re;
        in_twiddle[2*k+1] = l.w.im;
    endtask

    function automatic int rd(input int idx);
        return int'($signed(out_data[idx]));
    endfunction

    task automatic cmp_lane(input string tag, input int k, input lane_out_t e);
        chk({tag, "_xre"}, rd(4*k),   e.xr);
        chk({tag, "_xim"}, rd(4*k+1), e.xi);
        chk({tag, "_yre"}, rd(4*k+2), e.yr);
        chk({tag, "_yim"}, rd(4*k+3), e.yi);
    endtask

    function automatic lane_in_t rnd_lane();
        lane_in_t l;
        l.a.re = 16'($urandom); l.a.im = 16'($urandom);
        l.b.re = 16'($urandom); l.b.im = 16'($urandom);
        l.w.re = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
        l.w.im = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
        return l;
    endfunction

    vec_t      tbl[6];
    lane_in_t  stim[NTX][NB];
    bit        s_conj[NTX];
    bit        s_scale[NTX];
    lane_out_t sbq[$];
    bit        sbq_sat[$];

    initial begin
        int lat, sent, recv, stall, cyc, seen;
        bit stall_started, exp_sticky, txsat;
        logic [4*NB-1:0][DW-1:0] held;
        lane_out_t e;

        tbl[0] = mkv(1000, 0, 2000, 0, 32767, 0,      0, 0, 3000, 0, -1000, 0, 0);
        tbl[1] = mkv(1000, 0, 2000, 0, 32767, 0,      0, 1, 1500, 0, -500, 0, 0);
        tbl[2] = mkv(0, 0, 100, 50, 0, -32768,        0, 0, 50, -100, -50, 100, 0);
        tbl[3] = mkv(0, 0, 100, 50, 0, -32768,        1, 0, -50, 100, 50, -100, 0);
        tbl[4] = mkv(32767, 0, 32767, 0, 32767, 0,    0, 0, 32767, 0, 1, 0, 1);
        tbl[5] = mkv(32767, 0, 32767, 0, 32767, 0,    0, 1, 32767, 0, 1, 0, 0);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_twiddle = '0;
        in_conj = 1'b0; in_scale = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sticky", sat_sticky, 0);
        chk("rst_out_data_nonzero", (out_data != '0), 0);
        chk("rst_in_ready", in_ready, 1);

        // Directed vectors, lane 0 only, other lanes zero.
        exp_sticky = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_data = '0; in_twiddle = '0;
            put_lane(0, tbl[i].l);
            in_conj = tbl[i].conj; in_scale = tbl[i].scale;
            in_valid = 1'b1; out_ready = 1'b1;
            #1 chk("vec_in_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            for (int c = 1; c <= 8; c++) begin
                if (c > 1) begin @(posedge clk); #1; end
                if (out_valid) begin lat = c; break; end
            end
            chk("vec_latency", lat, 3);
            cmp_lane("vec_lane0", 0, tbl[i].exp);
            chk("vec_out_sat", out_sat, tbl[i].exp.sat);
            chk("vec_idle_lane_nonzero", (out_data[4*NB-1:4*NB-4] != '0), 0);
            exp_sticky = exp_sticky | tbl[i].exp.sat;
            @(posedge clk); #1;
            chk("vec_sticky", sat_sticky, exp_sticky);
            if (tbl[i].exp.sat) begin
                sat_clr = 1'b1;
                @(posedge clk); #1;
                sat_clr = 1'b0;
                exp_sticky = 1'b0;
                chk("sat_clr_sticky", sat_sticky, 0);
            end
        end

        // Randomized back-to-back stream with a 5-cycle output stall.
        for (int t = 0; t < NTX; t++) begin
            for (int k = 0; k < NB; k++) stim[t][k] = rnd_lane();
            stim[t][0].a.re = 16'(t * 100 + 7);
            s_conj[t]  = 1'($urandom);
            s_scale[t] = 1'($urandom);
        end
        sent = 0; recv = 0; stall = 0; cyc = 0; stall_started = 1'b0;
        exp_sticky = sat_sticky;
        held = '0;
        while (recv < NTX && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            if (!stall_started && recv == 8) begin stall = 5; stall_started = 1'b1; end
            out_ready = (stall == 0);
            if (sent < NTX) begin
                for (int k = 0; k < NB; k++) put_lane(k, stim[sent][k]);
                in_conj = s_conj[sent]; in_scale = s_scale[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("stream_sticky", sat_sticky, exp_sticky);
            if (in_valid && in_ready) begin
                txsat = 1'b0;
                for (int k = 0; k < NB; k++) begin
                    e = model(stim[sent][k], s_conj[sent], s_scale[sent]);
                    sbq.push_back(e);
                    txsat = txsat | e.sat;
                end
                sbq_sat.push_back(txsat);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sbq_sat.size() == 0) begin
                    chk("stream_extra_output", 1, 0);
                end else begin
                    for (int k = 0; k < NB; k++) cmp_lane("stream_lane", k, sbq.pop_front());
                    txsat = sbq_sat.pop_front();
                    chk("stream_out_sat", out_sat, txsat);
                    exp_sticky = exp_sticky | txsat;
                end
                recv++;
            end else if (out_valid) begin
                chk("stall_in_ready", in_ready, 0);
                if (stall == 5) held = out_data;
                else chk("stall_data_changed", (out_data != held), 0);
            end
            if (stall > 0) stall--;
        end
        chk("stream_recv", recv, NTX);
        chk("stream_sent", sent, NTX);
        chk("stream_stall_hit", stall_started, 1);
        chk("stream_leftover", sbq_sat.size(), 0);

        // Reset with three saturating transactions in flight.
        @(posedge clk); #1;
        in_data = '0; in_twiddle = '0; put_lane(0, tbl[4].l);
        in_conj = 1'b0; in_scale = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_sticky", sat_sticky, 1);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sticky", sat_sticky, 0);
        chk("midrst_out_sat", out_sat, 0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("post_rst_ghost_outputs", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
